// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared limits and Gray-code helpers for pointer clock-domain crossings
package cdc_pkg;

  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MAX_SYNC_STAGES   = 4;
  localparam int MAX_POINTER_WIDTH = 32;

  // Helpers take zero-extended pointers: leading zeros leave the low bits of the result exact.
  function automatic logic [MAX_POINTER_WIDTH-1:0] gray2bin(
    input logic [MAX_POINTER_WIDTH-1:0] gray
  );
    logic [MAX_POINTER_WIDTH-1:0] bin;
    bin[MAX_POINTER_WIDTH-1] = gray[MAX_POINTER_WIDTH-1];
    for (int i = MAX_POINTER_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [MAX_POINTER_WIDTH-1:0] bin2gray(
    input logic [MAX_POINTER_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic popcount_gt1(input logic [MAX_POINTER_WIDTH-1:0] value);
    return (value & (value - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/sync_pointer_gray2bin.sv
// rtl/sync_pointer_gray2bin.sv - combinational Gray to binary converter for FIFO pointers
module sync_pointer_gray2bin
  import cdc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  if (WIDTH < 1 || WIDTH > MAX_POINTER_WIDTH) begin : g_bad_width
    $error("sync_pointer_gray2bin: WIDTH=%0d outside 1..%0d", WIDTH, MAX_POINTER_WIDTH);
  end

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/sync_pointer_cdc.sv
// rtl/sync_pointer_cdc.sv - N-stage Gray pointer synchronizer with binary output, valid qualifier,
// change pulse and sticky Gray-integrity error
module sync_pointer_cdc
  import cdc_pkg::*;
#(
  parameter int ADDRESS_SIZE = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int CHECK_GRAY   = 1
) (
  input  logic                  write_clk,
  input  logic                  write_reset,
  input  logic [ADDRESS_SIZE:0] read_pointer,
  input  logic                  clear_error,
  output logic [ADDRESS_SIZE:0] write_to_read_pointer,
  output logic [ADDRESS_SIZE:0] write_to_read_pointer_bin,
  output logic                  sync_valid,
  output logic                  pointer_changed,
  output logic                  gray_error
);

  localparam int                 COUNT_WIDTH = $clog2(SYNC_STAGES + 2);
  localparam logic [COUNT_WIDTH-1:0] VALID_COUNT = COUNT_WIDTH'(SYNC_STAGES + 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("sync_pointer_cdc: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
    (* ASYNC_REG = "TRUE" *) logic [ADDRESS_SIZE:0] q;
    if (s == 0) begin : g_first
      always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) q <= '0;
        else             q <= read_pointer;
      end
    end else begin : g_next
      always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) q <= '0;
        else             q <= g_stage[s-1].q;
      end
    end
  end

  assign write_to_read_pointer = g_stage[SYNC_STAGES-1].q;

  logic [ADDRESS_SIZE:0] bin_next;
  logic [ADDRESS_SIZE:0] bin_prev;
  logic [COUNT_WIDTH-1:0] valid_count;

  sync_pointer_gray2bin #(
    .WIDTH (ADDRESS_SIZE + 1)
  ) u_gray2bin (
    .gray (write_to_read_pointer),
    .bin  (bin_next)
  );

  // Counter only reaches VALID_COUNT once every sync stage has been reloaded after reset.
  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      valid_count <= '0;
    end else if (valid_count != VALID_COUNT) begin
      valid_count <= valid_count + 1'b1;
    end
  end

  assign sync_valid = (valid_count == VALID_COUNT);

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      write_to_read_pointer_bin <= '0;
      bin_prev                  <= '0;
      pointer_changed           <= 1'b0;
    end else begin
      write_to_read_pointer_bin <= bin_next;
      bin_prev                  <= write_to_read_pointer_bin;
      pointer_changed           <= sync_valid && (write_to_read_pointer_bin != bin_prev);
    end
  end

  if (CHECK_GRAY != 0) begin : g_check
    logic [ADDRESS_SIZE:0] gray_prev;
    logic                  gray_step_illegal;

    assign gray_step_illegal =
      popcount_gt1(MAX_POINTER_WIDTH'(write_to_read_pointer ^ gray_prev));

    // A new violation outranks a coincident clear so no error is ever lost.
    always_ff @(posedge write_clk or posedge write_reset) begin
      if (write_reset) begin
        gray_prev  <= '0;
        gray_error <= 1'b0;
      end else begin
        gray_prev <= write_to_read_pointer;
        if (sync_valid && gray_step_illegal) gray_error <= 1'b1;
        else if (clear_error)                gray_error <= 1'b0;
      end
    end
  end else begin : g_no_check
    assign gray_error = 1'b0;
  end

endmodule

// File: tb/tb_sync_pointer_cdc.sv
// tb/tb_sync_pointer_cdc.sv - scoreboard bench for sync_pointer_cdc at 2, 3 and 4 sync stages
module tb_sync_pointer_cdc;

  localparam int K_G2 = 0, K_B2 = 1, K_V2 = 2, K_C2 = 3, K_E2 = 4;
  localparam int K_G3 = 5, K_B3 = 6, K_V3 = 7, K_C3 = 8;
  localparam int K_G4 = 9, K_B4 = 10, K_V4 = 11, K_C4 = 12;
  localparam int K_LAST = 12;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      tag;
  } item_t;

  logic clk = 1'b0;
  logic rst, clr;
  logic [3:0] rp2;
  logic [4:0] rp3, rp4;

  logic [3:0] g2, b2;
  logic [4:0] g3, b3, g4, b4;
  logic v2, c2, e2, v3, c3, e3, v4, c4, e4;

  item_t sb[$];
  int cyc = 0;
  int n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  sync_pointer_cdc dut2 (
    .write_clk(clk), .write_reset(rst), .read_pointer(rp2), .clear_error(clr),
    .write_to_read_pointer(g2), .write_to_read_pointer_bin(b2),
    .sync_valid(v2), .pointer_changed(c2), .gray_error(e2)
  );

  sync_pointer_cdc #(.ADDRESS_SIZE(4), .SYNC_STAGES(3)) dut3 (
    .write_clk(clk), .write_reset(rst), .read_pointer(rp3), .clear_error(clr),
    .write_to_read_pointer(g3), .write_to_read_pointer_bin(b3),
    .sync_valid(v3), .pointer_changed(c3), .gray_error(e3)
  );

  sync_pointer_cdc #(.ADDRESS_SIZE(4), .SYNC_STAGES(4)) dut4 (
    .write_clk(clk), .write_reset(rst), .read_pointer(rp4), .clear_error(clr),
    .write_to_read_pointer(g4), .write_to_read_pointer_bin(b4),
    .sync_valid(v4), .pointer_changed(c4), .gray_error(e4)
  );

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_G2:    return 8'(g2);
      K_B2:    return 8'(b2);
      K_V2:    return 8'(v2);
      K_C2:    return 8'(c2);
      K_E2:    return 8'(e2);
      K_G3:    return 8'(g3);
      K_B3:    return 8'(b3);
      K_V3:    return 8'(v3);
      K_C3:    return 8'(c3);
      K_G4:    return 8'(g4);
      K_B4:    return 8'(b4);
      K_V4:    return 8'(v4);
      K_C4:    return 8'(c4);
      default: return 8'hxx;
    endcase
  endfunction

  task automatic exp_at(input int k, input int kind, input logic [7:0] v, input string tag);
    item_t it;
    it.due  = cyc + k;
    it.kind = kind;
    it.exp  = v;
    it.tag  = tag;
    sb.push_back(it);
  endtask

  task automatic check_due();
    logic [7:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        obs = observe(sb[i].kind);
        n_total++;
        assert (obs === sb[i].exp) n_pass++;
        else begin
          n_fail++;
          $error("FAIL %s kind=%0d cyc=%0d: observed %0h expected %0h",
                 sb[i].tag, sb[i].kind, cyc, obs, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  initial begin
    int v;
    logic [3:0] g;

    // Reset hold with a non-zero pointer, then release and watch the chains flush.
    rst = 1'b1; clr = 1'b0; rp2 = 4'b1010; rp3 = '0; rp4 = '0;
    repeat (3) begin
      for (int k = 0; k <= K_LAST; k++) exp_at(1, k, 8'h00, "reset_hold");
      exp_at(1, K_E2, 8'h00, "reset_hold_err");
      step();
    end
    rst = 1'b0;
    exp_at(1, K_G2, 8'h0, "rel_gray_early"); exp_at(2, K_G2, 8'ha, "rel_gray");
    exp_at(2, K_B2, 8'h0, "rel_bin_early");  exp_at(3, K_B2, 8'hc, "rel_bin");
    exp_at(1, K_V2, 8'h0, "rel_valid2_e1");  exp_at(2, K_V2, 8'h0, "rel_valid2_e2");
    exp_at(3, K_V2, 8'h1, "rel_valid2_e3");
    exp_at(3, K_C2, 8'h0, "rel_no_pulse_first_valid");
    exp_at(4, K_C2, 8'h1, "rel_pulse"); exp_at(5, K_C2, 8'h0, "rel_pulse_end");
    exp_at(3, K_V3, 8'h0, "rel_valid3_e3"); exp_at(4, K_V3, 8'h1, "rel_valid3_e4");
    exp_at(4, K_V4, 8'h0, "rel_valid4_e4"); exp_at(5, K_V4, 8'h1, "rel_valid4_e5");
    exp_at(6, K_E2, 8'h0, "rel_no_err");
    repeat (7) step();

    // Re-reset with a zero pointer so the walk starts from 0.
    rst = 1'b1; rp2 = 4'b0000;
    step();
    rst = 1'b0;
    exp_at(6, K_V4, 8'h1, "rerst_valid4");
    exp_at(6, K_B2, 8'h0, "rerst_bin");
    repeat (6) step();

    // Latency of a single step 0 -> 1 at 2, 3 and 4 stages.
    rp2 = 4'd1; rp3 = 5'd1; rp4 = 5'd1;
    exp_at(1, K_G2, 8'h0, "lat2_gray_e1"); exp_at(2, K_G2, 8'h1, "lat2_gray");
    exp_at(2, K_B2, 8'h0, "lat2_bin_e2");  exp_at(3, K_B2, 8'h1, "lat2_bin");
    exp_at(3, K_C2, 8'h0, "lat2_chg_e3");  exp_at(4, K_C2, 8'h1, "lat2_chg");
    exp_at(5, K_C2, 8'h0, "lat2_chg_once");
    exp_at(2, K_G3, 8'h0, "lat3_gray_e2"); exp_at(3, K_G3, 8'h1, "lat3_gray");
    exp_at(3, K_B3, 8'h0, "lat3_bin_e3");  exp_at(4, K_B3, 8'h1, "lat3_bin");
    exp_at(5, K_C3, 8'h1, "lat3_chg");     exp_at(6, K_C3, 8'h0, "lat3_chg_once");
    exp_at(3, K_G4, 8'h0, "lat4_gray_e3"); exp_at(4, K_G4, 8'h1, "lat4_gray");
    exp_at(4, K_B4, 8'h0, "lat4_bin_e4");  exp_at(5, K_B4, 8'h1, "lat4_bin");
    exp_at(6, K_C4, 8'h1, "lat4_chg");     exp_at(7, K_C4, 8'h0, "lat4_chg_once");
    repeat (8) step();

    // Full legal Gray walk 2..15 and the wrap back to 0, one step per cycle.
    for (int i = 2; i <= 16; i++) begin
      v = i % 16;
      g = 4'(v ^ (v >> 1));
      rp2 = g;
      exp_at(2, K_G2, 8'(g), "walk_gray");
      exp_at(3, K_B2, 8'(v), "walk_bin");
      exp_at(4, K_C2, 8'h1, "walk_chg");
      step();
    end
    exp_at(4, K_C2, 8'h0, "walk_chg_end");
    exp_at(4, K_E2, 8'h0, "walk_no_err");
    repeat (6) step();

    // Illegal two-bit step, then clear alone, then clear coincident with a new violation.
    rp2 = 4'b0011;
    exp_at(2, K_E2, 8'h0, "err_not_yet"); exp_at(3, K_E2, 8'h1, "err_set");
    exp_at(6, K_E2, 8'h1, "err_sticky");
    repeat (8) step();
    clr = 1'b1;
    exp_at(1, K_E2, 8'h0, "err_cleared");
    step();
    clr = 1'b0;
    exp_at(2, K_E2, 8'h0, "err_stays_clear");
    repeat (2) step();
    rp2 = 4'b0000;
    repeat (2) step();
    clr = 1'b1;
    exp_at(1, K_E2, 8'h1, "err_set_beats_clear");
    step();
    clr = 1'b0;
    exp_at(2, K_E2, 8'h1, "err_sticky_after_race");
    repeat (2) step();

    // Asynchronous reset in the middle of a pointer stream.
    for (int i = 1; i <= 4; i++) begin
      rp2 = 4'(i ^ (i >> 1));
      if (i == 1) exp_at(4, K_C2, 8'h1, "stream_pulse");
      step();
    end
    rst = 1'b1; rp2 = 4'b0111;
    #1;
    for (int k = 0; k <= K_LAST; k++) exp_at(0, k, 8'h00, "async_reset");
    exp_at(0, K_E2, 8'h00, "async_reset_err");
    check_due();
    exp_at(1, K_V2, 8'h0, "midrst_hold");
    step();
    rst = 1'b0;
    exp_at(1, K_G2, 8'h0, "midrst_gray_flushed"); exp_at(2, K_G2, 8'h7, "midrst_gray");
    exp_at(3, K_B2, 8'h5, "midrst_bin");
    exp_at(2, K_V2, 8'h0, "midrst_valid2_e2");    exp_at(3, K_V2, 8'h1, "midrst_valid2");
    exp_at(3, K_C2, 8'h0, "midrst_no_pulse_first_valid");
    exp_at(4, K_C2, 8'h1, "midrst_pulse");        exp_at(5, K_C2, 8'h0, "midrst_pulse_end");
    exp_at(3, K_V3, 8'h0, "midrst_valid3_e3");    exp_at(4, K_V3, 8'h1, "midrst_valid3");
    exp_at(4, K_V4, 8'h0, "midrst_valid4_e4");    exp_at(5, K_V4, 8'h1, "midrst_valid4");
    exp_at(5, K_E2, 8'h0, "midrst_no_err");
    repeat (7) step();

    n_total++;
    assert (sb.size() == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL scoreboard_drained: observed %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
